// File: rtl/xoodoo_perm_ctrl_sca.sv
// Round sequencer for the DOM-masked Xoodoo core: owns both shares,
// counter and constants. Define XOODOO_SHARE_REFRESH_EN to remask at accept.
module xoodoo_perm_ctrl_sca #(
  parameter int NROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] in_0,
  input  logic [383:0] in_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] out_0,
  output logic [383:0] out_1,
  output logic         busy,
  input  logic         rng_valid,
  output logic         rng_ready,
  input  logic [383:0] rng_data,
  output logic [383:0] rnd_in_0,
  output logic [383:0] rnd_in_1,
  output logic [383:0] rnd_rs,
  output logic [31:0]  rnd_rconst,
  input  logic [383:0] rnd_out_0,
  input  logic [383:0] rnd_out_1
);

`ifdef XOODOO_SHARE_REFRESH_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_REFRESH,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;
  localparam state_t S_FIRST = S_REFRESH;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;
  localparam state_t S_FIRST = S_ISSUE;
`endif

  // Shorter permutations use the tail of the constant table
  localparam logic [3:0] RC_BASE  = 4'(12 - NROUNDS);
  localparam logic [3:0] CTR_LAST = 4'(NROUNDS - 1);

  state_t       state_q;
  state_t       state_d;
  logic [383:0] s0_q;
  logic [383:0] s0_d;
  logic [383:0] s1_q;
  logic [383:0] s1_d;
  logic [3:0]   ctr_q;
  logic [3:0]   ctr_d;
  logic         rc_en;

  function automatic logic [31:0] rc_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    rc_lut = 32'h0000_0058;
      4'd1:    rc_lut = 32'h0000_0038;
      4'd2:    rc_lut = 32'h0000_03C0;
      4'd3:    rc_lut = 32'h0000_00D0;
      4'd4:    rc_lut = 32'h0000_0120;
      4'd5:    rc_lut = 32'h0000_0014;
      4'd6:    rc_lut = 32'h0000_0060;
      4'd7:    rc_lut = 32'h0000_002C;
      4'd8:    rc_lut = 32'h0000_0380;
      4'd9:    rc_lut = 32'h0000_00F0;
      4'd10:   rc_lut = 32'h0000_01A0;
      4'd11:   rc_lut = 32'h0000_0012;
      default: rc_lut = 32'h0000_0000;
    endcase
  endfunction

  // FSM state, share pair and round counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next state, share updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    ctr_d     = ctr_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rng_ready = 1'b0;
    rc_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s0_d    = in_0;
          s1_d    = in_1;
          ctr_d   = '0;
          state_d = S_FIRST;
        end
      end
`ifdef XOODOO_SHARE_REFRESH_EN
      S_REFRESH: begin
        busy      = 1'b1;
        rng_ready = rng_valid;
        if (rng_valid) begin
          s0_d    = s0_q ^ rng_data;
          s1_d    = s1_q ^ rng_data;
          state_d = S_ISSUE;
        end
      end
`endif
      S_ISSUE: begin
        busy      = 1'b1;
        rc_en     = 1'b1;
        rng_ready = rng_valid;
        if (rng_valid) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy  = 1'b1;
        rc_en = 1'b1;
        s0_d  = rnd_out_0;
        s1_d  = rnd_out_1;
        if (ctr_q == CTR_LAST) begin
          state_d = S_DONE;
        end else begin
          ctr_d   = ctr_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rnd_in_0   = s0_q;
  assign rnd_in_1   = s1_q;
  assign rnd_rs     = rng_data;
  assign rnd_rconst = rc_en ? rc_lut(RC_BASE + ctr_q) : 32'h0;
  assign out_0      = s0_q;
  assign out_1      = s1_q;

endmodule
